// File: rtl/hazard_types_pkg.sv
// Shared types and helpers for the pipeline hazard/redirect controller.
package hazard_types_pkg;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } hazard_state_t;

  // True when a candidate stage index should replace the current best.
  // Strictly-greater keeps the lowest source index on ties when scanned upward.
  function automatic logic highest_stage_sel(input int unsigned cand,
                                             input int unsigned best,
                                             input logic        best_vld);
    return !best_vld || (cand > best);
  endfunction

endpackage

// File: rtl/redirect_arbiter.sv
// Combinational redirect arbiter: oldest requester (highest stage index) wins,
// lowest source index breaks ties.
module redirect_arbiter
  import hazard_types_pkg::*;
#(
  parameter int unsigned NUM_REDIR = 2,
  parameter int unsigned SW        = 3,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic [NUM_REDIR-1:0]        i_req,
  input  logic [NUM_REDIR*SW-1:0]     i_stage,
  input  logic [NUM_REDIR*ADDR_W-1:0] i_addr,
  output logic                        o_valid,
  output logic [NUM_REDIR-1:0]        o_onehot,
  output logic [SW-1:0]               o_stage,
  output logic [ADDR_W-1:0]           o_addr
);

  // Priority scan over all sources, keeping the running best.
  always_comb begin
    o_valid  = 1'b0;
    o_onehot = '0;
    o_stage  = '0;
    o_addr   = '0;
    for (int k = 0; k < int'(NUM_REDIR); k++) begin
      if (i_req[k] && highest_stage_sel(int'(i_stage[k*SW +: SW]), int'(o_stage), o_valid)) begin
        o_valid     = 1'b1;
        o_onehot    = '0;
        o_onehot[k] = 1'b1;
        o_stage     = i_stage[k*SW +: SW];
        o_addr      = i_addr[k*ADDR_W +: ADDR_W];
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/redirect controller for an N-stage in-order pipeline.
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
  import hazard_types_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 5,
  parameter int unsigned NUM_REDIR  = 2,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned CNT_W      = 32,
  localparam int unsigned SW        = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NUM_STAGES-1:0]       i_stage_wait,
  input  logic [NUM_REDIR-1:0]        i_redir_req,
  input  logic [NUM_REDIR*SW-1:0]     i_redir_stage,
  input  logic [NUM_REDIR*ADDR_W-1:0] i_redir_addr,
  output logic [NUM_STAGES-1:0]       o_stall,
  output logic [NUM_STAGES-1:0]       o_flush,
  output logic [NUM_REDIR-1:0]        o_redir_accept,
  output logic                        o_pc_redir_valid,
  output logic [ADDR_W-1:0]           o_pc_redir_addr,
  input  logic                        i_pc_redir_ready,
  output logic [CNT_W-1:0]            o_stall_cycles,
  output logic [CNT_W-1:0]            o_redir_count
);

  hazard_state_t         r_state, w_state_next;
  logic [ADDR_W-1:0]     r_addr;
  logic                  w_pending;
  logic                  w_win_valid;
  logic [NUM_REDIR-1:0]  w_win_onehot;
  logic [SW-1:0]         w_win_stage;
  logic [ADDR_W-1:0]     w_win_addr;
  logic                  w_win_stalled;
  logic                  w_accept;
  logic [NUM_STAGES-1:0] w_stall;

  assign w_pending = (r_state == PENDING);

  redirect_arbiter #(
    .NUM_REDIR (NUM_REDIR),
    .SW        (SW),
    .ADDR_W    (ADDR_W)
  ) u_arb (
    .i_req    (i_redir_req),
    .i_stage  (i_redir_stage),
    .i_addr   (i_redir_addr),
    .o_valid  (w_win_valid),
    .o_onehot (w_win_onehot),
    .o_stage  (w_win_stage),
    .o_addr   (w_win_addr)
  );

  // A stage stalls when it or any older stage waits; fetch also stalls on a pending redirect.
  always_comb begin
    w_stall = '0;
    for (int i = 0; i < int'(NUM_STAGES); i++) begin
      w_stall[i] = |(i_stage_wait >> i);
    end
    w_stall[0] = w_stall[0] | w_pending;
  end

  // Stall state at the winner's stage; an out-of-range index never accepts.
  always_comb begin
    w_win_stalled = 1'b1;
    for (int i = 0; i < int'(NUM_STAGES); i++) begin
      if (int'(w_win_stage) == i) w_win_stalled = w_stall[i];
    end
  end

  assign w_accept       = w_win_valid && !w_win_stalled && !i_rst;
  assign o_redir_accept = w_accept ? w_win_onehot : '0;
  assign o_stall        = w_stall;

  // Flush everything younger than an accepted requester; fetch is discarded while pending.
  always_comb begin
    o_flush = '0;
    if (i_rst) begin
      o_flush = '1;
    end else begin
      for (int i = 0; i < int'(NUM_STAGES); i++) begin
        o_flush[i] = w_accept && (i < int'(w_win_stage));
      end
      o_flush[0] = o_flush[0] | w_pending;
    end
  end

  // Next state: a new accept always wins over fetch consuming the old target.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_next = PENDING;
      PENDING: begin
        if (w_accept)              w_state_next = PENDING;
        else if (i_pc_redir_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State and latched redirect target.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) r_addr <= w_win_addr;
    end
  end

  assign o_pc_redir_valid = w_pending;
  assign o_pc_redir_addr  = r_addr;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cycles, r_redir_count;

  // Saturating perf counters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stall_cycles <= '0;
      r_redir_count  <= '0;
    end else begin
      if (w_stall[0] && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      if (w_accept && (r_redir_count != '1))    r_redir_count  <= r_redir_count + CNT_W'(1);
    end
  end

  assign o_stall_cycles = r_stall_cycles;
  assign o_redir_count  = r_redir_count;
`else
  assign o_stall_cycles = '0;
  assign o_redir_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (NUM_STAGES=5, NUM_REDIR=2, ADDR_W=32).
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  stage_wait;
  logic [1:0]  redir_req;
  logic [5:0]  redir_stage;
  logic [63:0] redir_addr;
  logic [4:0]  stall, flush;
  logic [1:0]  redir_accept;
  logic        pc_valid;
  logic [31:0] pc_addr;
  logic        pc_ready;
  logic [31:0] stall_cycles, redir_count;

  pipeline_hazard_ctrl #(
    .NUM_STAGES (5),
    .NUM_REDIR  (2),
    .ADDR_W     (32),
    .CNT_W      (32)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_stage_wait     (stage_wait),
    .i_redir_req      (redir_req),
    .i_redir_stage    (redir_stage),
    .i_redir_addr     (redir_addr),
    .o_stall          (stall),
    .o_flush          (flush),
    .o_redir_accept   (redir_accept),
    .o_pc_redir_valid (pc_valid),
    .o_pc_redir_addr  (pc_addr),
    .i_pc_redir_ready (pc_ready),
    .o_stall_cycles   (stall_cycles),
    .o_redir_count    (redir_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  stall;
    logic [4:0]  flush;
    logic [1:0]  acc;
    logic        valid;
    logic [31:0] addr;
  } out_t;

  typedef struct packed {
    logic        rst;
    logic [4:0]  wt;
    logic [1:0]  req;
    logic [2:0]  s0;
    logic [31:0] a0;
    logic [2:0]  s1;
    logic [31:0] a1;
    logic        rdy;
    out_t        e;
  } step_t;

  typedef struct packed {
    out_t        o;
    logic [31:0] sc;
    logic [31:0] rc;
  } sb_t;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned m_sc     = 0;
  int unsigned m_rc     = 0;
  sb_t         sb[$];
  step_t       steps[$];
  sb_t         want, got;

  function automatic step_t mk(input logic rst_v, input logic [4:0] wt, input logic [1:0] req,
                               input logic [2:0] s0, input logic [31:0] a0,
                               input logic [2:0] s1, input logic [31:0] a1, input logic rdy,
                               input logic [4:0] e_stall, input logic [4:0] e_flush,
                               input logic [1:0] e_acc, input logic e_valid,
                               input logic [31:0] e_addr);
    step_t s;
    s.rst = rst_v; s.wt = wt; s.req = req; s.s0 = s0; s.a0 = a0; s.s1 = s1; s.a1 = a1;
    s.rdy = rdy;
    s.e.stall = e_stall; s.e.flush = e_flush; s.e.acc = e_acc; s.e.valid = e_valid;
    s.e.addr = e_addr;
    return s;
  endfunction

  // Apply one cycle of stimulus and push its expected outcome (incl. counter model).
  task automatic drive(input step_t s);
    sb_t item;
    rst         = s.rst;
    stage_wait  = s.wt;
    redir_req   = s.req;
    redir_stage = {s.s1, s.s0};
    redir_addr  = {s.a1, s.a0};
    pc_ready    = s.rdy;
    if (s.rst) begin
      m_sc = 0;
      m_rc = 0;
    end
    item.o = s.e;
`ifdef HAZARD_PERF_CNT_EN
    item.sc = m_sc;
    item.rc = m_rc;
`else
    item.sc = '0;
    item.rc = '0;
`endif
    sb.push_back(item);
    if (!s.rst) begin
      m_sc = m_sc + 32'(s.e.stall[0]);
      m_rc = m_rc + 32'(|s.e.acc);
    end
  endtask

  function automatic sb_t observe();
    sb_t o;
    o.o.stall = stall; o.o.flush = flush; o.o.acc = redir_accept;
    o.o.valid = pc_valid; o.o.addr = pc_addr;
    o.sc = stall_cycles; o.rc = redir_count;
    return o;
  endfunction

  task automatic test_reset();
    steps = {};
    steps.push_back(mk(1, 5'b00000, 2'b00, 0, 0,         0, 0, 0, 5'b00000, 5'b11111, 2'b00, 0, 0));
    steps.push_back(mk(1, 5'b01000, 2'b01, 2, 32'h900,   0, 0, 0, 5'b01111, 5'b11111, 2'b00, 0, 0));
    steps.push_back(mk(0, 5'b00000, 2'b00, 0, 0,         0, 0, 0, 5'b00000, 5'b00000, 2'b00, 0, 0));
    foreach (steps[n]) begin
      drive(steps[n]);
      @(negedge clk);
      want = sb.pop_front();
      got  = observe();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL reset step %0d: got %h required %h", n, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall();
    steps = {};
    steps.push_back(mk(0, 5'b01000, 2'b00, 0, 0,       0, 0, 0, 5'b01111, 5'b00000, 2'b00, 0, 0));
    steps.push_back(mk(0, 5'b10000, 2'b00, 0, 0,       0, 0, 0, 5'b11111, 5'b00000, 2'b00, 0, 0));
    steps.push_back(mk(0, 5'b00001, 2'b00, 0, 0,       0, 0, 0, 5'b00001, 5'b00000, 2'b00, 0, 0));
    steps.push_back(mk(0, 5'b01000, 2'b01, 2, 32'h900, 0, 0, 0, 5'b01111, 5'b00000, 2'b00, 0, 0));
    steps.push_back(mk(0, 5'b00000, 2'b00, 0, 0,       0, 0, 0, 5'b00000, 5'b00000, 2'b00, 0, 0));
    foreach (steps[n]) begin
      drive(steps[n]);
      @(negedge clk);
      want = sb.pop_front();
      got  = observe();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL stall step %0d: got %h required %h", n, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_redirect();
    steps = {};
    steps.push_back(mk(0, 0, 2'b01, 2, 32'h100, 0, 0, 0, 5'b00000, 5'b00011, 2'b01, 0, 32'h0));
    steps.push_back(mk(0, 0, 2'b00, 0, 0,       0, 0, 0, 5'b00001, 5'b00001, 2'b00, 1, 32'h100));
    steps.push_back(mk(0, 0, 2'b00, 0, 0,       0, 0, 1, 5'b00001, 5'b00001, 2'b00, 1, 32'h100));
    steps.push_back(mk(0, 0, 2'b00, 0, 0,       0, 0, 0, 5'b00000, 5'b00000, 2'b00, 0, 32'h100));
    foreach (steps[n]) begin
      drive(steps[n]);
      @(negedge clk);
      want = sb.pop_front();
      got  = observe();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL redirect step %0d: got %h required %h", n, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_arbitration();
    steps = {};
    steps.push_back(mk(0, 0, 2'b11, 2, 32'h100, 3, 32'h200, 0, 5'b00000, 5'b00111, 2'b10, 0, 32'h100));
    steps.push_back(mk(0, 0, 2'b00, 0, 0,       0, 0,       1, 5'b00001, 5'b00001, 2'b00, 1, 32'h200));
    steps.push_back(mk(0, 0, 2'b00, 0, 0,       0, 0,       0, 5'b00000, 5'b00000, 2'b00, 0, 32'h200));
    // Tie on stage index: lowest source wins.
    steps.push_back(mk(0, 0, 2'b11, 3, 32'h400, 3, 32'h500, 0, 5'b00000, 5'b00111, 2'b01, 0, 32'h200));
    steps.push_back(mk(0, 0, 2'b00, 0, 0,       0, 0,       1, 5'b00001, 5'b00001, 2'b00, 1, 32'h400));
    steps.push_back(mk(0, 0, 2'b00, 0, 0,       0, 0,       0, 5'b00000, 5'b00000, 2'b00, 0, 32'h400));
    foreach (steps[n]) begin
      drive(steps[n]);
      @(negedge clk);
      want = sb.pop_front();
      got  = observe();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL arbitration step %0d: got %h required %h", n, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    steps = {};
    steps.push_back(mk(0, 0, 2'b01, 2, 32'h100, 0, 0,       0, 5'b00000, 5'b00011, 2'b01, 0, 32'h400));
    steps.push_back(mk(0, 0, 2'b00, 0, 0,       0, 0,       0, 5'b00001, 5'b00001, 2'b00, 1, 32'h100));
    steps.push_back(mk(0, 0, 2'b10, 0, 0,       4, 32'h300, 0, 5'b00001, 5'b01111, 2'b10, 1, 32'h100));
    steps.push_back(mk(0, 0, 2'b00, 0, 0,       0, 0,       0, 5'b00001, 5'b00001, 2'b00, 1, 32'h300));
    // Accept while fetch consumes: new target supersedes, stays pending.
    steps.push_back(mk(0, 0, 2'b01, 3, 32'h600, 0, 0,       1, 5'b00001, 5'b00111, 2'b01, 1, 32'h300));
    steps.push_back(mk(0, 0, 2'b00, 0, 0,       0, 0,       0, 5'b00001, 5'b00001, 2'b00, 1, 32'h600));
    steps.push_back(mk(0, 0, 2'b00, 0, 0,       0, 0,       1, 5'b00001, 5'b00001, 2'b00, 1, 32'h600));
    steps.push_back(mk(0, 0, 2'b00, 0, 0,       0, 0,       0, 5'b00000, 5'b00000, 2'b00, 0, 32'h600));
    foreach (steps[n]) begin
      drive(steps[n]);
      @(negedge clk);
      want = sb.pop_front();
      got  = observe();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL back_to_back step %0d: got %h required %h", n, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_blocked();
    steps = {};
    for (int c = 0; c < 3; c++) begin
      steps.push_back(mk(0, 5'b10000, 2'b10, 0, 0, 2, 32'h700, 0,
                         5'b11111, 5'b00000, 2'b00, 0, 32'h600));
    end
    steps.push_back(mk(0, 5'b00000, 2'b10, 0, 0, 2, 32'h700, 0, 5'b00000, 5'b00011, 2'b10, 0, 32'h600));
    steps.push_back(mk(0, 5'b00000, 2'b00, 0, 0, 0, 0,       1, 5'b00001, 5'b00001, 2'b00, 1, 32'h700));
    steps.push_back(mk(0, 5'b00000, 2'b00, 0, 0, 0, 0,       0, 5'b00000, 5'b00000, 2'b00, 0, 32'h700));
    foreach (steps[n]) begin
      drive(steps[n]);
      @(negedge clk);
      want = sb.pop_front();
      got  = observe();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL blocked step %0d: got %h required %h", n, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_pending();
    steps = {};
    steps.push_back(mk(0, 0, 2'b01, 2, 32'h800, 0, 0, 0, 5'b00000, 5'b00011, 2'b01, 0, 32'h700));
    steps.push_back(mk(0, 0, 2'b00, 0, 0,       0, 0, 0, 5'b00001, 5'b00001, 2'b00, 1, 32'h800));
    // Reset applied mid-cycle and sampled before any clock edge.
    steps.push_back(mk(1, 0, 2'b00, 0, 0,       0, 0, 0, 5'b00000, 5'b11111, 2'b00, 0, 32'h0));
    steps.push_back(mk(0, 0, 2'b00, 0, 0,       0, 0, 0, 5'b00000, 5'b00000, 2'b00, 0, 32'h0));
    foreach (steps[n]) begin
      drive(steps[n]);
      @(negedge clk);
      want = sb.pop_front();
      got  = observe();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL reset_pending step %0d: got %h required %h", n, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst         = 1'b1;
    stage_wait  = '0;
    redir_req   = '0;
    redir_stage = '0;
    redir_addr  = '0;
    pc_ready    = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_stall();
    test_redirect();
    test_arbitration();
    test_back_to_back();
    test_blocked();
    test_reset_pending();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
